// File: rtl/namuru_status_flags_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : namuru_status_flags_pkg
//  Purpose  : Shared constants for the status-flag block: default channel
//             count, default epoch width and bit positions in the status word.
//  Revision : 1.0 - initial release
// ============================================================================
package namuru_status_flags_pkg;

    localparam int c_NUM_CHAN_DEF = 12;
    localparam int c_EPOCH_W_DEF  = 16;

    // Bit positions inside the 2-bit status word {accum_flag, tic_flag}
    localparam int c_STAT_TIC     = 0;
    localparam int c_STAT_ACCUM   = 1;

endpackage : namuru_status_flags_pkg
`default_nettype wire

// File: rtl/namuru_status_flags_if.sv
`default_nettype none
// ============================================================================
//  Module   : namuru_status_flags_if
//  Purpose  : Bundle of event pulses, CPU read strobes and status outputs
//             between the time base / correlator channels / bus register
//             file (master side) and the status-flag block (slave side).
//  Signals  : tic_enable, accum_enable, dump[NUM_CHAN], status_read,
//             new_data_read                        (master -> slave)
//             accum_int, status[2], new_data[NUM_CHAN], overrun[NUM_CHAN],
//             tic_epoch[EPOCH_W]                   (slave -> master)
//  Revision : 1.0 - initial release
// ============================================================================
interface namuru_status_flags_if
    import namuru_status_flags_pkg::*;
#(
    parameter int NUM_CHAN = c_NUM_CHAN_DEF,
    parameter int EPOCH_W  = c_EPOCH_W_DEF
);
    logic                tic_enable;
    logic                accum_enable;
    logic [NUM_CHAN-1:0] dump;
    logic                status_read;
    logic                new_data_read;
    logic                accum_int;
    logic [1:0]          status;
    logic [NUM_CHAN-1:0] new_data;
    logic [NUM_CHAN-1:0] overrun;
    logic [EPOCH_W-1:0]  tic_epoch;

    modport master (
        output tic_enable, accum_enable, dump, status_read, new_data_read,
        input  accum_int, status, new_data, overrun, tic_epoch
    );

    modport slave (
        input  tic_enable, accum_enable, dump, status_read, new_data_read,
        output accum_int, status, new_data, overrun, tic_epoch
    );

endinterface : namuru_status_flags_if
`default_nettype wire

// File: rtl/namuru_status_flags_sticky_flag.sv
`default_nettype none
// ============================================================================
//  Module   : namuru_sticky_flag
//  Purpose  : Single sticky flag bit. Set has priority over clear so that an
//             event arriving in the same cycle as the CPU read is never lost.
//  Ports    : clk  - clock
//             rst  - synchronous active-high reset (overrides set/clr)
//             set  - set request
//             clr  - clear request
//             q    - registered flag value
//  Revision : 1.0 - initial release
// ============================================================================
module namuru_sticky_flag (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic set,
    input  wire logic clr,
    output logic      q
);

    logic r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= 1'b0;
        end else if (set) begin
            r_q <= 1'b1;
        end else if (clr) begin
            r_q <= 1'b0;
        end
    end

    assign q = r_q;

endmodule : namuru_sticky_flag
`default_nettype wire

// File: rtl/namuru_status_flags.sv
`default_nettype none
// ============================================================================
//  Module   : namuru_status_flags
//  Purpose  : Converts time-base TIC / accumulation pulses and per-channel
//             dump pulses into sticky, read-to-clear status flags, a level
//             accumulation interrupt and a free-running TIC epoch counter.
//  Ports    : clk   - system clock (time base domain)
//             rstn  - synchronous reset, active-high
//             sf    - namuru_status_flags_if slave modport (pulses in,
//                     status / new_data / overrun / tic_epoch / accum_int out)
//  Revision : 1.0 - initial release
// ============================================================================
module namuru_status_flags
    import namuru_status_flags_pkg::*;
#(
    parameter int NUM_CHAN = c_NUM_CHAN_DEF,
    parameter int EPOCH_W  = c_EPOCH_W_DEF
) (
    input  wire logic               clk,
    input  wire logic               rstn,
    namuru_status_flags_if.slave    sf
);

    logic                w_tic_flag;
    logic                w_accum_flag;
    logic [NUM_CHAN-1:0] w_new_data;
    logic [NUM_CHAN-1:0] w_overrun;
    logic [NUM_CHAN-1:0] w_ovr_set;
    logic [EPOCH_W-1:0]  r_tic_epoch;

    namuru_sticky_flag u_tic_flag (
        .clk (clk),
        .rst (rstn),
        .set (sf.tic_enable),
        .clr (sf.status_read),
        .q   (w_tic_flag)
    );

    namuru_sticky_flag u_accum_flag (
        .clk (clk),
        .rst (rstn),
        .set (sf.accum_enable),
        .clr (sf.status_read),
        .q   (w_accum_flag)
    );

    for (genvar i = 0; i < NUM_CHAN; i++) begin : g_chan
        // Overrun only when the previous sample is still unread; a dump that
        // coincides with the read replaces consumed data and is not an overrun.
        assign w_ovr_set[i] = sf.dump[i] & w_new_data[i] & ~sf.new_data_read;

        namuru_sticky_flag u_new_data (
            .clk (clk),
            .rst (rstn),
            .set (sf.dump[i]),
            .clr (sf.new_data_read),
            .q   (w_new_data[i])
        );

        namuru_sticky_flag u_overrun (
            .clk (clk),
            .rst (rstn),
            .set (w_ovr_set[i]),
            .clr (sf.new_data_read),
            .q   (w_overrun[i])
        );
    end

    // TIC epoch counter, wraps naturally at 2^EPOCH_W
    always_ff @(posedge clk) begin
        if (rstn) begin
            r_tic_epoch <= '0;
        end else if (sf.tic_enable) begin
            r_tic_epoch <= r_tic_epoch + 1'b1;
        end
    end

    assign sf.status[c_STAT_TIC]   = w_tic_flag;
    assign sf.status[c_STAT_ACCUM] = w_accum_flag;
    assign sf.accum_int            = w_accum_flag;
    assign sf.new_data             = w_new_data;
    assign sf.overrun              = w_overrun;
    assign sf.tic_epoch            = r_tic_epoch;

endmodule : namuru_status_flags
`default_nettype wire

// File: tb/tb_namuru_status_flags.sv
`default_nettype none
// ============================================================================
//  Module   : tb_namuru_status_flags
//  Purpose  : Self-checking bench for namuru_status_flags. A behavioural
//             model tracks flags as bit-vectors and the epoch as an integer;
//             DUT outputs are compared to it on every falling edge, and a
//             set of directed scenarios pins exact values.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_namuru_status_flags;

    localparam int NUM_CHAN = 12;
    localparam int EPOCH_W  = 16;
    localparam logic [NUM_CHAN-1:0] c_MASK = '1;

    logic clk  = 1'b0;
    logic rstn = 1'b1;
    always #5 clk = ~clk;

    namuru_status_flags_if #(.NUM_CHAN(NUM_CHAN), .EPOCH_W(EPOCH_W)) sf ();

    namuru_status_flags #(.NUM_CHAN(NUM_CHAN), .EPOCH_W(EPOCH_W)) dut (
        .clk  (clk),
        .rstn (rstn),
        .sf   (sf)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Behavioural model
    bit                  m_tic, m_acc;
    logic [NUM_CHAN-1:0] m_nd, m_ov;
    int                  m_epoch;

    initial begin
        m_tic = 0; m_acc = 0; m_nd = '0; m_ov = '0; m_epoch = 0;
    end

    always @(posedge clk) begin
        if (rstn) begin
            m_tic = 0; m_acc = 0; m_nd = '0; m_ov = '0; m_epoch = 0;
        end else begin
            // Flag = (old value unless read) OR new event
            m_tic = (m_tic && !sf.status_read) || sf.tic_enable;
            m_acc = (m_acc && !sf.status_read) || sf.accum_enable;
            if (sf.new_data_read) begin
                m_ov = '0;
                m_nd = sf.dump;
            end else begin
                m_ov = m_ov | (sf.dump & m_nd);
                m_nd = m_nd | sf.dump;
            end
            if (sf.tic_enable) m_epoch = (m_epoch + 1) % (1 << EPOCH_W);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_accum_int", {31'd0, sf.accum_int}, {31'd0, m_acc});
            check("model_status",    {30'd0, sf.status},    {30'd0, m_acc, m_tic});
            check("model_new_data",  {20'd0, sf.new_data},  {20'd0, m_nd});
            check("model_overrun",   {20'd0, sf.overrun},   {20'd0, m_ov});
            check("model_tic_epoch", {16'd0, sf.tic_epoch}, m_epoch);
        end
    end

    // Apply inputs for one cycle; returns at the following falling edge,
    // when outputs reflect the cycle just applied.
    task automatic drive(input logic r, input logic t, input logic a,
                         input logic [NUM_CHAN-1:0] d, input logic sr, input logic ndr);
        rstn             = r;
        sf.tic_enable    = t;
        sf.accum_enable  = a;
        sf.dump          = d;
        sf.status_read   = sr;
        sf.new_data_read = ndr;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(0, 0, 0, '0, 0, 0);
    endtask

    initial begin
        // 1: reset overrides every input
        drive(1, 1, 1, c_MASK, 1, 1);
        drive(1, 1, 1, c_MASK, 1, 1);
        chk_en = 1'b1;
        check("rst_accum_int", {31'd0, sf.accum_int}, 32'd0);
        check("rst_status",    {30'd0, sf.status},    32'd0);
        check("rst_new_data",  {20'd0, sf.new_data},  32'd0);
        check("rst_overrun",   {20'd0, sf.overrun},   32'd0);
        check("rst_tic_epoch", {16'd0, sf.tic_epoch}, 32'd0);

        // 2: accumulation interrupt set / clear / set-wins
        idle(3);
        drive(0, 0, 1, '0, 0, 0);
        check("acc_int_set",    {31'd0, sf.accum_int}, 32'd1);
        check("acc_status_set", {30'd0, sf.status},    32'd2);
        idle(4);
        check("acc_int_held",   {31'd0, sf.accum_int}, 32'd1);
        drive(0, 0, 0, '0, 1, 0);
        check("acc_int_clr",    {31'd0, sf.accum_int}, 32'd0);
        drive(0, 0, 1, '0, 1, 0);
        check("acc_set_wins",   {31'd0, sf.accum_int}, 32'd1);
        drive(0, 0, 0, '0, 1, 0);
        check("acc_int_clr2",   {31'd0, sf.accum_int}, 32'd0);

        // 3: double dump on channel 3 -> overrun, read clears both
        drive(0, 0, 0, 12'h008, 0, 0);
        idle(2);
        drive(0, 0, 0, 12'h008, 0, 0);
        check("ovr_new_data", {20'd0, sf.new_data}, 32'h008);
        check("ovr_overrun",  {20'd0, sf.overrun},  32'h008);
        idle(1);
        drive(0, 0, 0, '0, 0, 1);
        check("ovr_clr_nd", {20'd0, sf.new_data}, 32'h000);
        check("ovr_clr_ov", {20'd0, sf.overrun},  32'h000);

        // 4: dump coincident with read is fresh data, not overrun
        drive(0, 0, 0, 12'h001, 0, 0);
        drive(0, 0, 0, 12'h001, 0, 1);
        check("coinc_new_data", {20'd0, sf.new_data}, 32'h001);
        check("coinc_overrun",  {20'd0, sf.overrun},  32'h000);
        drive(0, 0, 0, '0, 0, 1);

        // 5: epoch wrap
        for (int k = 0; k < 65535; k++) drive(0, 1, 0, '0, 0, 0);
        check("epoch_max", {16'd0, sf.tic_epoch}, 32'h0000FFFF);
        drive(0, 0, 0, '0, 1, 0);
        check("tic_flag_clr", {30'd0, sf.status}, 32'd0);
        drive(0, 1, 0, '0, 0, 0);
        check("epoch_wrap", {16'd0, sf.tic_epoch}, 32'h00000000);
        check("wrap_tic_flag", {30'd0, sf.status}, 32'd1);

        // 6: all channels dump at once
        drive(0, 0, 0, c_MASK, 0, 0);
        check("all_new_data", {20'd0, sf.new_data}, 32'h0FFF);
        check("all_overrun",  {20'd0, sf.overrun},  32'h0000);

        // Randomized phase, including occasional mid-operation resets
        for (int k = 0; k < 4000; k++) begin
            drive(($urandom_range(0, 199) == 0),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 5) == 0),
                  NUM_CHAN'($urandom & $urandom),
                  ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 4) == 0));
        end

        // Final mid-operation reset discards everything
        drive(0, 1, 1, c_MASK, 0, 0);
        drive(0, 0, 0, c_MASK, 0, 0);
        drive(1, 0, 0, '0, 0, 0);
        check("midrst_overrun", {20'd0, sf.overrun}, 32'd0);
        check("midrst_status",  {30'd0, sf.status},  32'd0);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_namuru_status_flags
`default_nettype wire
